// File: rtl/alu_arbiter_if.sv
// Bundles the requester, ALU-side and response signals of alu_arbiter.
// Perf counter signals exist only when ALU_ARB_PERF_EN is defined.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  // Every channel uses the same handshake: a transfer happens on a rising
  // clk edge where valid and ready are both 1. The source holds valid and its
  // payload stable until that edge, and ready never depends on a future valid.
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [DATA_W-1:0] req0_a_i;
  logic [DATA_W-1:0] req0_b_i;
  logic [CTRL_W-1:0] req0_ctrl_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [DATA_W-1:0] req1_a_i;
  logic [DATA_W-1:0] req1_b_i;
  logic [CTRL_W-1:0] req1_ctrl_i;

  logic [DATA_W-1:0] alu_data1_o;
  logic [DATA_W-1:0] alu_data2_o;
  logic [CTRL_W-1:0] alu_ctrl_o;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_zero_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_id_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_zero_o;

  logic              busy_o;

`ifdef ALU_ARB_PERF_EN
  logic [15:0]       grant_cnt0_o;
  logic [15:0]       grant_cnt1_o;
  logic [15:0]       stall_cnt_o;
`endif

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_ctrl_i,
    output req0_ready_o,
    input  req1_valid_i, req1_a_i, req1_b_i, req1_ctrl_i,
    output req1_ready_o,
    output alu_data1_o, alu_data2_o, alu_ctrl_o,
    input  alu_data_i, alu_zero_i,
    output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o,
    input  rsp_ready_i,
    output busy_o
`ifdef ALU_ARB_PERF_EN
    , output grant_cnt0_o, grant_cnt1_o, stall_cnt_o
`endif
  );

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_ctrl_i,
    input  req0_ready_o,
    output req1_valid_i, req1_a_i, req1_b_i, req1_ctrl_i,
    input  req1_ready_o,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o,
    output alu_data_i, alu_zero_i,
    input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o,
    output rsp_ready_i,
    input  busy_o
`ifdef ALU_ARB_PERF_EN
    , input grant_cnt0_o, grant_cnt1_o, stall_cnt_o
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with
// a held MUL window. Optional perf counters: define ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 3,
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_arbiter_if.slave bus,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Control encoding shared with the ALU: AND,XOR,SLL,ADD,SUB,MUL,SRAI,OR = 0..7.
  localparam logic [CTRL_W-1:0] CTRL_MUL = CTRL_W'(5);
  localparam logic [3:0]        MUL_CNT  = 4'(MUL_LAT - 1);

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              id_q;
  logic [DATA_W-1:0] data_q;
  logic              zero_q;

  logic              gnt0, gnt1, accept, sel;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [CTRL_W-1:0] sel_ctrl;

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        gnt0 = bus.req0_valid_i && (!bus.req1_valid_i || last_grant_q);
        gnt1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_grant_q);
        if (gnt0 || gnt1) state_d = EXEC;
      end
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept   = gnt0 || gnt1;
  assign sel      = gnt1;
  assign sel_a    = sel ? bus.req1_a_i    : bus.req0_a_i;
  assign sel_b    = sel ? bus.req1_b_i    : bus.req0_b_i;
  assign sel_ctrl = sel ? bus.req1_ctrl_i : bus.req0_ctrl_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      id_q         <= 1'b0;
      data_q       <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= sel_a;
        b_q          <= sel_b;
        ctrl_q       <= sel_ctrl;
        id_q         <= sel;
        last_grant_q <= sel;
        cnt_q        <= (sel_ctrl == CTRL_MUL) ? MUL_CNT : 4'd0;
      end
      if (state_q == EXEC) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          data_q <= bus.alu_data_i;
          zero_q <= bus.alu_zero_i;
        end
      end
    end
  end

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;
  assign bus.alu_data1_o  = a_q;
  assign bus.alu_data2_o  = b_q;
  assign bus.alu_ctrl_o   = ctrl_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_id_o     = id_q;
  assign bus.rsp_data_o   = data_q;
  assign bus.rsp_zero_o   = zero_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign state_o          = state_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] grant0_q, grant1_q, stall_q;
  logic        stall;

  // One stall per cycle even when both requesters are blocked.
  assign stall = (bus.req0_valid_i && !gnt0) || (bus.req1_valid_i && !gnt1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant0_q <= 16'd0;
      grant1_q <= 16'd0;
      stall_q  <= 16'd0;
    end else begin
      if (gnt0 && grant0_q != 16'hFFFF) grant0_q <= grant0_q + 16'd1;
      if (gnt1 && grant1_q != 16'hFFFF) grant1_q <= grant1_q + 16'd1;
      if (stall && stall_q != 16'hFFFF) stall_q  <= stall_q + 16'd1;
    end
  end

  assign bus.grant_cnt0_o = grant0_q;
  assign bus.grant_cnt1_o = grant1_q;
  assign bus.stall_cnt_o  = stall_q;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the EX-stage issue port (req0) and a multi-cycle helper such as the address/branch unit (req1).
- Grants round-robin, registers operands into the ALU, and holds MUL operands for a programmable number of cycles.
- Returns the registered result and zero flag on a single response channel with a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width; matches `DATA_LEN.
- CTRL_W, 3, ALU control width; matches `CRTL_LEN.
- MUL_LAT, 3, EXEC cycles for a `MUL operation; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_a_i  in  DATA_W  operand 1
- req0_b_i  in  DATA_W  operand 2
- req0_ctrl_i  in  CTRL_W  ALU control code (`AND/`XOR/`SLL/`ADD/`SUB/`MUL/`SRAI/`OR)
- req1_valid_i / req1_ready_o / req1_a_i / req1_b_i / req1_ctrl_i  same as requester 0
- alu_data1_o  out  DATA_W  registered operand 1 to ALU
- alu_data2_o  out  DATA_W  registered operand 2 to ALU
- alu_ctrl_o  out  CTRL_W  registered control to ALU
- alu_data_i  in  DATA_W  ALU result
- alu_zero_i  in  1  ALU zero flag
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  consumer takes response
- rsp_id_o  out  1  requester that owns the response
- rsp_data_o  out  DATA_W  captured result
- rsp_zero_o  out  1  captured zero flag
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - FSM=IDLE; all alu_*_o, rsp_data_o, rsp_zero_o, rsp_id_o = 0; rsp_valid_o=0; busy_o=0.
  - last_grant=1, so req0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one valid, grant it. If both valid, grant the requester != last_grant.
  - reqN_ready_o=1 only for the granted requester, and only in IDLE. A ready without valid never occurs.
  - On grant: latch a/b/ctrl into alu_*_o, set rsp_id_o and last_grant to N, load cnt = (ctrl==`MUL) ? MUL_LAT-1 : 0, go EXEC.
- EXEC:
  - alu_*_o held constant.
  - If cnt!=0: decrement.
  - If cnt==0: capture alu_data_i into rsp_data_o and alu_zero_i into rsp_zero_o, go RESP.
- RESP:
  - rsp_valid_o=1; rsp_data_o, rsp_zero_o and rsp_id_o are stable until handshake.
  - When rsp_ready_i=1, go IDLE; rsp_valid_o falls next cycle.
  - No grant in the same cycle as the response handshake.
- Latency, accept edge to rsp_valid_o high:
  - non-MUL: 2 cycles.
  - MUL: MUL_LAT+1 cycles.
  - Minimum issue interval: 3 cycles non-MUL.
- Back-pressure: rsp_ready_i low holds RESP indefinitely. Both ready_o stay 0. Requesters must hold valid and operands stable until ready.
- busy_o=1 in EXEC and RESP.
- Unknown ctrl codes pass through unchanged to the ALU with 1-cycle EXEC. The result is whatever the ALU holds.
- SRAI/SLL operand semantics belong to the ALU; no masking here.
- Reset mid-operation: any state returns to IDLE next edge. The in-flight op is dropped with no response; last_grant returns to 1.
- valid dropped by a requester while not granted: legal, no effect.

Optional Feature:
ALU_ARB_PERF_EN:
- When defined, adds outputs grant_cnt0_o and grant_cnt1_o (16 bits each), plus stall_cnt_o (16 bits).
- grant_cntN_o counts accepted grants per requester. stall_cnt_o counts cycles with reqN_valid_i=1 and reqN_ready_o=0 for either N, once per cycle.
- All three saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then req0 only, ADD a=5 b=7 -> req0_ready_o pulses in IDLE cycle; rsp_valid_o high 2 cycles later with rsp_data_o=12, rsp_zero_o=0, rsp_id_o=0.
- Both valid continuously (req0 SUB 9-9, req1 XOR 3^5), rsp_ready_i=1 -> grants alternate 0,1,0,1; req0 responses data=0 zero=1; req1 responses data=6 zero=0.
- MUL_LAT=3, req1 MUL 6*7 -> alu_*_o stable 3 EXEC cycles; rsp_valid_o at accept+4 with data=42, id=1.
- rsp_ready_i held 0 for 5 cycles after rsp_valid_o -> data, zero and id unchanged; no ready_o pulses; on rsp_ready_i=1, IDLE next cycle and new grant the following cycle.
- rst_i asserted in EXEC of a MUL -> next cycle busy_o=0, rsp_valid_o=0, all outputs 0; following both-valid tie grants req0.
- With ALU_ARB_PERF_EN: 3 req0 grants, 2 req1 grants and 4 blocked-valid cycles -> grant_cnt0_o=3, grant_cnt1_o=2, stall_cnt_o=4.
